hnf_rxreq_link_ctrl: RTL and testbench

Link-layer controller for the HN-F RXREQ channel. Runs the CHI receiver link-activation state machine (rxlinkactivereq/ack), issues L-credits on `rxreqlcrdv` only while the request position queue (posq) has room, counts credits held by the RN, and generates the posq write strobe for accepted request flits. It sits between the RN TXREQ link and the posq FIFO, and replaces free-running credit signalling with bounded, tracked credit issue.

---
 rtl/hnf_rxreq_link_ctrl.sv | 136 +++++++++++++
 tb/tb_hnf_rxreq_link_ctrl.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/hnf_rxreq_link_ctrl.sv
// hnf_rxreq_link_ctrl
// Link-layer controller for the HN-F RXREQ channel. Runs the receiver
// link-activation handshake, issues L-credits only while the posq has room,
// tracks credits held by the RN and strobes posq writes for accepted flits.
//
// Ports:
//   clock            sole clock, rising edge
//   rst_n            synchronous active-low reset
//   rxlinkactivereq  link activate request from the RN transmitter
//   rxlinkactiveack  link activate acknowledge (registered)
//   rxreqflitv       request flit valid
//   rxreqflitpend    flit pending (checked only with HNF_RXREQ_PEND_CHK_EN)
//   rxreq_opcode     opcode of current flit, 0x00 = ReqLCrdReturn
//   rxreqlcrdv       L-credit grant pulse (registered)
//   posq_wr          posq write strobe (combinational)
//   posq_pop         posq entry dequeued
//   link_state       0=STOP 1=ACTIVATE 2=RUN 3=DEACTIVATE
//   crd_out          credits currently held by the RN
//   posq_occ         posq occupancy mirror
//   proto_err        sticky protocol-error flag
//
// Build option: define HNF_RXREQ_PEND_CHK_EN to require rxreqflitpend in the
// cycle before every accepted flit.
//
// state       | meaning
// ------------+------------------------------------------------------
// STOP        | link down, no credits outstanding, ack low
// ACTIVATE    | request seen, one settling cycle before RUN
// RUN         | link up, credits issued while posq has room
// DEACTIVATE  | req dropped, wait for RN to hand back every credit

module hnf_rxreq_link_ctrl #(
  parameter int NUM_CRD = 4,
  parameter int CRD_W   = $clog2(NUM_CRD + 1)
) (
  input  logic             clock,
  input  logic             rst_n,
  input  logic             rxlinkactivereq,
  output logic             rxlinkactiveack,
  input  logic             rxreqflitv,
  input  logic             rxreqflitpend,
  input  logic [5:0]       rxreq_opcode,
  output logic             rxreqlcrdv,
  output logic             posq_wr,
  input  logic             posq_pop,
  output logic [1:0]       link_state,
  output logic [CRD_W-1:0] crd_out,
  output logic [CRD_W-1:0] posq_occ,
  output logic             proto_err
);

  typedef enum logic [1:0] {
    ST_STOP       = 2'd0,
    ST_ACTIVATE   = 2'd1,
    ST_RUN        = 2'd2,
    ST_DEACTIVATE = 2'd3
  } link_state_t;

  localparam logic [CRD_W:0] CRD_LIMIT = (CRD_W + 1)'(NUM_CRD);

  link_state_t      state, state_next;
  logic             link_up;
  logic             pend_ok;
  logic             consume;
  logic             pop_ok;
  logic             flit_err, pop_err;
  logic [CRD_W-1:0] crd_out_n, occ_n;
  logic [CRD_W:0]   crd_sum_n;
  logic             lcrdv_n, ack_n;

`ifdef HNF_RXREQ_PEND_CHK_EN
  logic pend_q;

  always_ff @(posedge clock) begin
    if (!rst_n) pend_q <= 1'b0;
    else        pend_q <= rxreqflitpend;
  end

  assign pend_ok = pend_q;
`else
  logic unused_pend;
  assign unused_pend = rxreqflitpend;
  assign pend_ok     = 1'b1;
`endif

  assign link_up  = (state == ST_RUN) || (state == ST_DEACTIVATE);
  assign consume  = rxreqflitv && (crd_out != '0) && link_up && pend_ok;
  // Credit returns burn a credit but never occupy a posq entry.
  assign posq_wr  = rst_n && consume && (rxreq_opcode != 6'h00);
  assign flit_err = rxreqflitv && !consume;
  assign pop_ok   = posq_pop && (posq_occ != '0);
  assign pop_err  = posq_pop && (posq_occ == '0);

  // Neither counter can wrap: a grant is only issued with headroom below
  // NUM_CRD, and a consume requires a credit held by the RN.
  assign crd_out_n = crd_out + CRD_W'(rxreqlcrdv) - CRD_W'(consume);
  assign occ_n     = posq_occ + CRD_W'(posq_wr) - CRD_W'(pop_ok);
  assign crd_sum_n = {1'b0, crd_out_n} + {1'b0, occ_n};

  always_comb begin
    state_next = state;
    case (state)
      ST_STOP:       if (rxlinkactivereq) state_next = ST_ACTIVATE;
      ST_ACTIVATE:   state_next = ST_RUN;
      ST_RUN:        if (!rxlinkactivereq) state_next = ST_DEACTIVATE;
      ST_DEACTIVATE: if (crd_out_n == '0) state_next = ST_STOP;
      default:       state_next = ST_STOP;
    endcase

    ack_n = (state_next == ST_RUN) || (state_next == ST_DEACTIVATE);
    // Credits start only once RUN is already established, so the first grant
    // lands one cycle after ack rises.
    lcrdv_n = (state == ST_RUN) && (state_next == ST_RUN) && (crd_sum_n < CRD_LIMIT);
  end

  always_ff @(posedge clock) begin
    if (!rst_n) begin
      state           <= ST_STOP;
      rxlinkactiveack <= 1'b0;
      rxreqlcrdv      <= 1'b0;
      crd_out         <= '0;
      posq_occ        <= '0;
      proto_err       <= 1'b0;
    end else begin
      state           <= state_next;
      rxlinkactiveack <= ack_n;
      rxreqlcrdv      <= lcrdv_n;
      crd_out         <= crd_out_n;
      posq_occ        <= occ_n;
      if (flit_err || pop_err) proto_err <= 1'b1;
    end
  end

  assign link_state = state;

endmodule

// File: tb/tb_hnf_rxreq_link_ctrl.sv
// Directed bench for hnf_rxreq_link_ctrl with NUM_CRD=4.
// Inputs change 1 time unit after a rising edge; outputs are checked there.

module tb_hnf_rxreq_link_ctrl;

  localparam int NUM_CRD = 4;
  localparam int CRD_W   = $clog2(NUM_CRD + 1);

  logic             clock = 1'b0;
  logic             rst_n;
  logic             rxlinkactivereq;
  logic             rxlinkactiveack;
  logic             rxreqflitv;
  logic             rxreqflitpend;
  logic [5:0]       rxreq_opcode;
  logic             rxreqlcrdv;
  logic             posq_wr;
  logic             posq_pop;
  logic [1:0]       link_state;
  logic [CRD_W-1:0] crd_out;
  logic [CRD_W-1:0] posq_occ;
  logic             proto_err;

  int  n_checks = 0;
  int  n_errors = 0;
  bit  done     = 1'b0;

  always #5 clock = ~clock;

  hnf_rxreq_link_ctrl #(.NUM_CRD(NUM_CRD)) dut (
    .clock           (clock),
    .rst_n           (rst_n),
    .rxlinkactivereq (rxlinkactivereq),
    .rxlinkactiveack (rxlinkactiveack),
    .rxreqflitv      (rxreqflitv),
    .rxreqflitpend   (rxreqflitpend),
    .rxreq_opcode    (rxreq_opcode),
    .rxreqlcrdv      (rxreqlcrdv),
    .posq_wr         (posq_wr),
    .posq_pop        (posq_pop),
    .link_state      (link_state),
    .crd_out         (crd_out),
    .posq_occ        (posq_occ),
    .proto_err       (proto_err)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk_state(input string tag, input int st, input int ack, input int lcrdv,
                           input int crd, input int occ);
    chk({tag, ".state"}, 32'(link_state), 32'(st));
    chk({tag, ".ack"},   32'(rxlinkactiveack), 32'(ack));
    chk({tag, ".lcrdv"}, 32'(rxreqlcrdv), 32'(lcrdv));
    chk({tag, ".crd"},   32'(crd_out), 32'(crd));
    chk({tag, ".occ"},   32'(posq_occ), 32'(occ));
  endtask

  // Credits held plus posq entries never exceed the posq depth.
  always @(negedge clock) begin
    if (rst_n === 1'b1 && !done)
      chk("invariant", 32'(int'(crd_out) + int'(posq_occ) <= NUM_CRD), 32'd1);
  end

  initial begin
    rst_n = 1'b0; rxlinkactivereq = 1'b0; rxreqflitv = 1'b0; rxreqflitpend = 1'b1;
    rxreq_opcode = 6'h01; posq_pop = 1'b0;
    tick(); tick();
    chk_state("reset", 0, 0, 0, 0, 0);
    chk("reset.err", 32'(proto_err), 32'd0);
    chk("reset.wr",  32'(posq_wr), 32'd0);

    // Bring-up: req high from cycle 0
    rst_n = 1'b1; rxlinkactivereq = 1'b1;
    tick(); chk_state("up1", 1, 0, 0, 0, 0);
    tick(); chk_state("up2", 2, 1, 0, 0, 0);
    for (int c = 3; c <= 6; c++) begin
      tick(); chk_state($sformatf("up%0d", c), 2, 1, 1, c - 3, 0);
    end
    tick(); chk_state("up7", 2, 1, 0, 4, 0);
    tick(); chk_state("up8", 2, 1, 0, 4, 0);

    // Two ReadShared flits
    rxreqflitv = 1'b1; rxreq_opcode = 6'h01; #1;
    chk("tr.wr0", 32'(posq_wr), 32'd1);
    tick(); chk_state("tr1", 2, 1, 0, 3, 1);
    chk("tr.wr1", 32'(posq_wr), 32'd1);
    tick(); chk_state("tr2", 2, 1, 0, 2, 2);
    rxreqflitv = 1'b0; posq_pop = 1'b1;
    tick(); chk_state("pop1", 2, 1, 1, 2, 1);
    posq_pop = 1'b0;
    tick(); chk_state("pop2", 2, 1, 0, 3, 1);

    // Reach crd=1 occ=3
    rxreqflitv = 1'b1;
    tick(); chk_state("fill1", 2, 1, 0, 2, 2);
    tick(); chk_state("fill2", 2, 1, 0, 1, 3);
    // Flit and pop together
    posq_pop = 1'b1;
    tick(); chk_state("sim1", 2, 1, 1, 0, 3);
    rxreqflitv = 1'b0; posq_pop = 1'b0;
    tick(); chk_state("sim2", 2, 1, 0, 1, 3);

    // Pops back to crd=3 occ=1
    posq_pop = 1'b1;
    tick(); chk_state("drain1", 2, 1, 1, 1, 2);
    tick(); chk_state("drain2", 2, 1, 1, 2, 1);
    posq_pop = 1'b0;
    tick(); chk_state("drain3", 2, 1, 0, 3, 1);
    chk("drain.err", 32'(proto_err), 32'd0);

    // Deactivate with three credit returns
    rxlinkactivereq = 1'b0;
    tick(); chk_state("deact0", 3, 1, 0, 3, 1);
    rxreqflitv = 1'b1; rxreq_opcode = 6'h00; #1;
    chk("deact.wr", 32'(posq_wr), 32'd0);
    tick(); chk_state("deact1", 3, 1, 0, 2, 1);
    chk("deact.wr1", 32'(posq_wr), 32'd0);
    tick(); chk_state("deact2", 3, 1, 0, 1, 1);
    tick(); chk_state("deact3", 0, 0, 0, 0, 1);
    chk("deact.err", 32'(proto_err), 32'd0);

    // Flit with no credit
    rxreq_opcode = 6'h01; #1;
    chk("err.wr", 32'(posq_wr), 32'd0);
    tick(); chk_state("err1", 0, 0, 0, 0, 1);
    chk("err.flit", 32'(proto_err), 32'd1);
    rxreqflitv = 1'b0;
    tick(); chk("err.sticky", 32'(proto_err), 32'd1);

    // Reset clears state; then pop on empty posq
    rst_n = 1'b0;
    tick(); chk_state("rst2", 0, 0, 0, 0, 0);
    chk("rst2.err", 32'(proto_err), 32'd0);
    rst_n = 1'b1; posq_pop = 1'b1;
    tick(); chk("pop_err", 32'(proto_err), 32'd1);
    chk("pop_err.occ", 32'(posq_occ), 32'd0);
    posq_pop = 1'b0;
    tick(); chk("pop_err.sticky", 32'(proto_err), 32'd1);

`ifdef HNF_RXREQ_PEND_CHK_EN
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1; rxlinkactivereq = 1'b1;
    for (int c = 1; c <= 8; c++) tick();
    chk_state("pend.up", 2, 1, 0, 4, 0);
    rxreqflitpend = 1'b0;
    tick();
    rxreqflitv = 1'b1; #1;
    chk("pend.nowr", 32'(posq_wr), 32'd0);
    tick(); chk_state("pend.drop", 2, 1, 0, 4, 0);
    chk("pend.err", 32'(proto_err), 32'd1);
    rxreqflitv = 1'b0; rxreqflitpend = 1'b1;
    tick();
    rxreqflitv = 1'b1; #1;
    chk("pend.wr", 32'(posq_wr), 32'd1);
    tick(); chk_state("pend.ok", 2, 1, 0, 3, 1);
    rxreqflitv = 1'b0;
    tick();
`endif

    done = 1'b1;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
